// File: rtl/k_alu_issue_unit.sv
// Flow-controlled issue stage for the combinational K_ALU_32: request FIFO -> ALU -> registered response.
// Optional rsp_zero output enabled by defining K_ALU_ISSUE_ZERO_FLAG_EN.
module k_alu_issue_unit #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_a,
  input  logic [WIDTH-1:0]         req_b,
  input  logic [SEL_W-1:0]         req_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_res,
  output logic [SEL_W-1:0]         rsp_sel,
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
  output logic                     rsp_zero,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SEL_W-1:0] sel;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             head;

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_res_q, rsp_res_d;
  logic [SEL_W-1:0]   rsp_sel_q, rsp_sel_d;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
  logic               rsp_zero_q, rsp_zero_d;
`endif

  logic               empty;
  logic               push;
  logic               issue;

  // req_ready depends on the occupancy register alone, so a same-cycle pop
  // when full does not open the input until the following cycle.
  assign empty     = (count_q == '0);
  assign req_ready = (count_q != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign issue     = !empty && (!rsp_valid_q || rsp_ready);

  assign head    = mem_q[rd_ptr_q];
  assign alu_a   = empty ? '0 : head.a;
  assign alu_b   = empty ? '0 : head.b;
  assign alu_sel = empty ? '0 : head.sel;

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_sel   = rsp_sel_q;
  assign count     = count_q;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
  assign rsp_zero  = rsp_zero_q;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_sel_d   = rsp_sel_q;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
    rsp_zero_d  = rsp_zero_q;
`endif

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, issue})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (issue) begin
      rsp_valid_d = 1'b1;
      rsp_res_d   = alu_res;
      rsp_sel_d   = head.sel;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
      rsp_zero_d  = (alu_res == '0);
`endif
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_sel_q   <= '0;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
      rsp_zero_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_sel_q   <= rsp_sel_d;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
      rsp_zero_q  <= rsp_zero_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_a, req_b, req_sel};
  end

endmodule

// File: tb/tb_k_alu_issue_unit.sv
// Directed self-checking bench for k_alu_issue_unit with an adder standing in for the ALU.
// Define K_ALU_ISSUE_ZERO_FLAG_EN to also exercise rsp_zero.
module tb_k_alu_issue_unit;

  localparam int WIDTH = 32;
  localparam int SEL_W = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [WIDTH-1:0]  req_a = '0;
  logic [WIDTH-1:0]  req_b = '0;
  logic [SEL_W-1:0]  req_sel = '0;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_res;
  logic [SEL_W-1:0]  alu_sel;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [WIDTH-1:0]  rsp_res;
  logic [SEL_W-1:0]  rsp_sel;
  logic [$clog2(DEPTH):0] count;
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
  logic              rsp_zero;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign alu_res = alu_a + alu_b;

  k_alu_issue_unit #(.WIDTH(WIDTH), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_sel   (rsp_sel),
`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
    .rsp_zero  (rsp_zero),
`endif
    .count     (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int a, input int b, input int sel);
    req_valid = v;
    req_a     = WIDTH'(a);
    req_b     = WIDTH'(b);
    req_sel   = SEL_W'(sel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_count", count, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_sel", rsp_sel, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_sel", alu_sel, 0);
    rst = 1'b0;
    tick();

    // Single op
    rsp_ready = 1'b1;
    drive(1, 150, 78, 3);
    tick();
    drive(0, 0, 0, 0);
    check("single_alu_a", alu_a, 150);
    check("single_alu_b", alu_b, 78);
    check("single_alu_sel", alu_sel, 3);
    check("single_no_bypass", rsp_valid, 0);
    tick();
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_res", rsp_res, 228);
    check("single_rsp_sel", rsp_sel, 3);
    check("single_count", count, 0);
    tick();
    check("single_rsp_clear", rsp_valid, 0);

    // Fill with backpressure: first request moves to response reg, four stay queued
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1, i, 2 * i, i);
      tick();
    end
    check("fill_count", count, 4);
    check("fill_req_ready", req_ready, 0);
    check("fill_rsp_res", rsp_res, 3);
    check("fill_rsp_sel", rsp_sel, 1);
    // Push while full is dropped
    drive(1, 6, 12, 6);
    tick();
    check("full_drop_count", count, 4);
    check("stall_rsp_res", rsp_res, 3);
    check("stall_rsp_valid", rsp_valid, 1);

    // Simultaneous push + pop while full
    rsp_ready = 1'b1;
    #1;
    check("full_pop_req_ready", req_ready, 0);
    tick();
    drive(0, 0, 0, 0);
    check("full_pop_count", count, 3);
    check("full_pop_req_ready_next", req_ready, 1);
    check("drain_res_6", rsp_res, 6);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check("drain_valid", rsp_valid, 1);
      check("drain_res", rsp_res, 3 * i);
      check("drain_sel", rsp_sel, i);
    end
    check("drain_count", count, 0);
    tick();
    check("drain_done", rsp_valid, 0);

    // Streaming at full rate
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive(1, i, 10, i);
      else       drive(0, 0, 0, 0);
      tick();
      check("stream_count_le1", count <= 1, 1);
      if (i >= 1) begin
        check("stream_valid", rsp_valid, 1);
        check("stream_res", rsp_res, 10 + i - 1);
        check("stream_sel", rsp_sel, i - 1);
      end
    end
    tick();
    check("stream_end", rsp_valid, 0);

    // Async reset mid-stream
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1, 20 + i, 1, i);
      tick();
    end
    drive(0, 0, 0, 0);
    check("pre_rst_count", count, 3);
    check("pre_rst_valid", rsp_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", rsp_valid, 0);
    check("async_rst_count", count, 0);
    check("async_rst_res", rsp_res, 0);
    check("async_rst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    drive(1, 1, 1, 5);
    tick();
    drive(0, 0, 0, 0);
    check("post_rst_alu_a", alu_a, 1);
    check("post_rst_count", count, 1);
    tick();
    check("post_rst_valid", rsp_valid, 1);
    check("post_rst_res", rsp_res, 2);
    check("post_rst_sel", rsp_sel, 5);
    tick();
    check("post_rst_empty", count, 0);

`ifdef K_ALU_ISSUE_ZERO_FLAG_EN
    drive(1, 0, 0, 2);
    tick();
    drive(1, 1, 0, 4);
    tick();
    drive(0, 0, 0, 0);
    check("zero_res0", rsp_res, 0);
    check("zero_flag1", rsp_zero, 1);
    tick();
    check("zero_res1", rsp_res, 1);
    check("zero_flag0", rsp_zero, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
